cpu_rst_seq: RTL and testbench

//  Reset sequencer in the CPU clock domain, downstream of the PXIE force-reset pulse-stretch/2-FF synchronizer.

---
 rtl/cpu_rst_seq.sv | 152 +++++++++++++++
 tb/tb_cpu_rst_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_rst_seq.sv
// CPU-domain reset sequencer: synchronized force-reset request -> fixed-length active-low CPU reset,
// 4-phase ack, done pulse and saturating sequence count. Optional retire watchdog under CPU_RST_WDT_EN.
module cpu_rst_seq #(
   parameter int unsigned RST_HOLD = 16,
   parameter int unsigned SETTLE   = 8,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned WDT_CYC  = 1024
) (
   input  logic             I_clk_100mhz,
   input  logic             I_Rst,
   input  logic             I_clk_locked,
   input  logic             I_force_req,
   input  logic             I_retire,
   output logic             O_cpu_rst_b,
   output logic             O_ack,
   output logic             O_busy,
   output logic             O_done,
   output logic [CNT_W-1:0] O_rst_cnt,
   output logic             O_wdt_err
);

   localparam int unsigned MAX_HS  = (RST_HOLD > SETTLE) ? RST_HOLD : SETTLE;
   localparam int unsigned MAX_CYC = (MAX_HS > WDT_CYC) ? MAX_HS : WDT_CYC;
   localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

   localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      RELEASE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          req_q;
   logic          req_edge_c;
   logic          wdt_fire_c;

   assign req_edge_c = I_force_req & ~req_q;

   // Sequencer; lock loss overrides everything, a new request edge restarts the hold.
   always_ff @(posedge I_clk_100mhz or posedge I_Rst) begin
      if (I_Rst) begin
         state       <= ASSERT;
         cnt         <= '0;
         req_q       <= 1'b0;
         O_cpu_rst_b <= 1'b0;
         O_ack       <= 1'b0;
         O_busy      <= 1'b1;
         O_done      <= 1'b0;
         O_rst_cnt   <= '0;
      end else begin
         req_q  <= I_force_req;
         O_done <= 1'b0;

         if (req_edge_c)
            O_ack <= 1'b1;
         else if (!I_force_req)
            O_ack <= 1'b0;

         if (!I_clk_locked || req_edge_c || wdt_fire_c) begin
            state       <= ASSERT;
            cnt         <= '0;
            O_cpu_rst_b <= 1'b0;
            O_busy      <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  O_cpu_rst_b <= 1'b1;
                  O_busy      <= 1'b0;
               end
               ASSERT: begin
                  if (cnt == HOLD_LAST) begin
                     state       <= RELEASE;
                     cnt         <= '0;
                     O_cpu_rst_b <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               RELEASE: begin
                  if (cnt == SETTLE_LAST) begin
                     state  <= DONE;
                     cnt    <= '0;
                     O_done <= 1'b1;
                     if (O_rst_cnt != '1)
                        O_rst_cnt <= O_rst_cnt + CNT_W'(1);
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               DONE: begin
                  state  <= IDLE;
                  O_busy <= 1'b0;
               end
               default: state <= ASSERT;
            endcase
         end
      end
   end

`ifdef CPU_RST_WDT_EN
   localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYC - 1);

   logic          wdt_act;
   logic          wdt_arm;
   logic [CW-1:0] wdt_cnt;

   assign wdt_fire_c = wdt_act & ~I_retire & (wdt_cnt == WDT_LAST) & (state == IDLE)
                     & I_clk_locked & ~req_edge_c;

   // Retire window after each armed completion; arm is re-granted only by a host request.
   always_ff @(posedge I_clk_100mhz or posedge I_Rst) begin
      if (I_Rst) begin
         wdt_act   <= 1'b0;
         wdt_arm   <= 1'b1;
         wdt_cnt   <= '0;
         O_wdt_err <= 1'b0;
      end else begin
         if (req_edge_c)
            wdt_arm <= 1'b1;

         if (!I_clk_locked || req_edge_c) begin
            wdt_act <= 1'b0;
         end else if (O_done && wdt_arm) begin
            wdt_act <= 1'b1;
            wdt_cnt <= CW'(1);
         end else if (wdt_act) begin
            if (I_retire) begin
               wdt_act <= 1'b0;
            end else if (wdt_fire_c) begin
               wdt_act   <= 1'b0;
               wdt_arm   <= 1'b0;
               O_wdt_err <= 1'b1;
            end else begin
               wdt_cnt <= wdt_cnt + CW'(1);
            end
         end
      end
   end
`else
   logic unused_retire_c;

   assign unused_retire_c = I_retire;
   assign wdt_fire_c      = 1'b0;
   assign O_wdt_err       = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_rst_seq.sv
// Directed bench for cpu_rst_seq: power-on, host request/ack, restart, lock loss, count saturation,
// and the retire watchdog (or its absence in the default build).
module tb_cpu_rst_seq;

   logic        W_clk;
   logic        W_Rst;
   logic        W_clk_locked;
   logic        W_force_req;
   logic        W_retire;
   logic        W_cpu_rst_b;
   logic        W_ack;
   logic        W_busy;
   logic        W_done;
   logic [15:0] W_rst_cnt;
   logic        W_wdt_err;

   int n_chk  = 0;
   int n_fail = 0;

   logic rb [200];
   logic dn [200];

   cpu_rst_seq dut (
      .I_clk_100mhz (W_clk),
      .I_Rst        (W_Rst),
      .I_clk_locked (W_clk_locked),
      .I_force_req  (W_force_req),
      .I_retire     (W_retire),
      .O_cpu_rst_b  (W_cpu_rst_b),
      .O_ack        (W_ack),
      .O_busy       (W_busy),
      .O_done       (W_done),
      .O_rst_cnt    (W_rst_cnt),
      .O_wdt_err    (W_wdt_err)
   );

   initial W_clk = 1'b0;
   always #5 W_clk = ~W_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Record reset/done once per falling edge, starting with the current one.
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         rb[i] = W_cpu_rst_b;
         dn[i] = W_done;
         @(negedge W_clk);
      end
   endtask

   function automatic int n_low(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (rb[i] == 1'b0) c++;
      return c;
   endfunction

   function automatic int last_low(input int n);
      int k = -1;
      for (int i = 0; i < n; i++) if (rb[i] == 1'b0) k = i;
      return k;
   endfunction

   function automatic int n_done(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (dn[i] == 1'b1) c++;
      return c;
   endfunction

   function automatic int first_done(input int n);
      for (int i = 0; i < n; i++) if (dn[i] == 1'b1) return i;
      return -1;
   endfunction

   initial begin
      W_Rst        = 1'b1;
      W_clk_locked = 1'b1;
      W_force_req  = 1'b0;
      W_retire     = 1'b0;
      repeat (3) @(negedge W_clk);

      check("rst_cpu_rst_b", 32'(W_cpu_rst_b), 32'd0);
      check("rst_busy",      32'(W_busy),      32'd1);
      check("rst_ack",       32'(W_ack),       32'd0);
      check("rst_done",      32'(W_done),      32'd0);
      check("rst_cnt",       32'(W_rst_cnt),   32'd0);
      check("rst_wdt_err",   32'(W_wdt_err),   32'd0);

      // Power-on: sample 0 is taken right after reset falls.
      W_Rst = 1'b0;
      capture(40);
      check("por_low_cycles", 32'(n_low(40)),      32'd16);
      check("por_last_low",   32'(last_low(40)),   32'd15);
      check("por_done_at",    32'(first_done(40)), 32'd24);
      check("por_done_cnt",   32'(n_done(40)),     32'd1);
      check("por_rst_cnt",    32'(W_rst_cnt),      32'd1);
      check("por_idle",       32'(W_busy),         32'd0);
      repeat (5) @(negedge W_clk);

      // Host request held 40 cycles.
      fork
         capture(45);
         begin
            W_force_req = 1'b1;
            @(negedge W_clk);
            check("req_ack_set", 32'(W_ack), 32'd1);
            repeat (39) @(negedge W_clk);
            check("req_ack_held", 32'(W_ack), 32'd1);
            W_force_req = 1'b0;
            @(negedge W_clk);
            check("req_ack_clr", 32'(W_ack), 32'd0);
         end
      join
      check("req_low_cycles", 32'(n_low(45)),      32'd16);
      check("req_last_low",   32'(last_low(45)),   32'd16);
      check("req_done_at",    32'(first_done(45)), 32'd25);
      check("req_done_cnt",   32'(n_done(45)),     32'd1);
      check("req_rst_cnt",    32'(W_rst_cnt),      32'd2);
      repeat (5) @(negedge W_clk);

      // Second request edge after 10 low cycles restarts the hold.
      fork
         capture(45);
         begin
            W_force_req = 1'b1;
            @(negedge W_clk);
            W_force_req = 1'b0;
            repeat (9) @(negedge W_clk);
            W_force_req = 1'b1;
            @(negedge W_clk);
            W_force_req = 1'b0;
         end
      join
      check("rst_low_cycles", 32'(n_low(45)),      32'd26);
      check("rst_last_low",   32'(last_low(45)),   32'd26);
      check("rst_done_at",    32'(first_done(45)), 32'd35);
      check("rst_done_cnt",   32'(n_done(45)),     32'd1);
      check("rst_rst_cnt",    32'(W_rst_cnt),      32'd3);
      check("rst_ack_low",    32'(W_ack),          32'd0);
      repeat (5) @(negedge W_clk);

      // Lock lost for 5 cycles in the middle of RELEASE.
      fork
         capture(55);
         begin
            W_force_req = 1'b1;
            @(negedge W_clk);
            W_force_req = 1'b0;
            repeat (17) @(negedge W_clk);
            W_clk_locked = 1'b0;
            repeat (5) @(negedge W_clk);
            W_clk_locked = 1'b1;
         end
      join
      check("lck_released", 32'(rb[17]),           32'd1);
      check("lck_reassert", 32'(rb[19]),           32'd0);
      check("lck_low_cyc",  32'(n_low(55)),        32'd36);
      check("lck_last_low", 32'(last_low(55)),     32'd38);
      check("lck_done_at",  32'(first_done(55)),   32'd47);
      check("lck_done_cnt", 32'(n_done(55)),       32'd1);
      check("lck_rst_cnt",  32'(W_rst_cnt),        32'd4);
      repeat (5) @(negedge W_clk);

      // Saturated sequence count.
      force dut.O_rst_cnt = 16'hFFFF;
      #1;
      release dut.O_rst_cnt;
      @(negedge W_clk);
      fork
         capture(30);
         begin
            W_force_req = 1'b1;
            @(negedge W_clk);
            W_force_req = 1'b0;
         end
      join
      check("sat_done_at",  32'(first_done(30)), 32'd25);
      check("sat_done_cnt", 32'(n_done(30)),     32'd1);
      check("sat_rst_cnt",  32'(W_rst_cnt),      32'h0000FFFF);

      // Long idle with no retire after the last completion.
`ifdef CPU_RST_WDT_EN
      begin
         int lows   = 0;
         int err_at = -1;
         for (int j = 0; j < 2200; j++) begin
            if (err_at < 0 && W_wdt_err) err_at = j;
            if (!W_cpu_rst_b) lows++;
            @(negedge W_clk);
         end
         check("wdt_err_at",   32'(err_at),    32'd1019);
         check("wdt_err",      32'(W_wdt_err), 32'd1);
         check("wdt_auto_low", 32'(lows),      32'd16);
         check("wdt_idle",     32'(W_busy),    32'd0);
      end
`else
      begin
         int lows = 0;
         for (int j = 0; j < 1100; j++) begin
            if (!W_cpu_rst_b) lows++;
            @(negedge W_clk);
         end
         check("idle_no_auto", 32'(lows),      32'd0);
         check("idle_wdt_err", 32'(W_wdt_err), 32'd0);
         check("idle_busy",    32'(W_busy),    32'd0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
